// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-cycle-latency IMEM reads and
// buffers returned words with their PCs for a valid/ready handoff to decode.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr_o,
  output logic        imem_read_n_o,
  input  logic [31:0] imem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [31:0]      pc_q;
  logic [31:0]      inflight_pc_q;
  logic             inflight_q;
  logic [31:0]      buf_pc_q    [BUF_DEPTH];
  logic [31:0]      buf_instr_q [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W:0]   credit;
  logic             buf_nonempty;
  logic             deq;
  logic             push;
  logic             issue;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc_i[1:0];

  assign buf_nonempty = (count_q != '0);
  assign id_valid_o   = reset_n & buf_nonempty & ~redirect_i;
  assign deq          = id_valid_o & id_ready_i;
  assign push         = inflight_q & ~redirect_i;

  // Credit counts buffered plus in-flight words, so an issued read always has a slot.
  assign credit = (CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(deq);
  assign issue  = reset_n & ~redirect_i & (credit < (CNT_W+1)'(BUF_DEPTH));

  assign imem_addr_o   = {pc_q[31:2], 2'b00};
  assign imem_read_n_o = ~issue;

  assign id_instr_o = buf_nonempty ? buf_instr_q[rd_ptr_q] : NOP;
  assign id_pc_o    = buf_nonempty ? buf_pc_q[rd_ptr_q]    : 32'h0000_0000;

  always_comb begin
    count_d = count_q;
    case ({push, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: reset, then redirect flush, then normal issue/push/pop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q          <= {RESET_PC[31:2], 2'b00};
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0000_0000;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else if (redirect_i) begin
      pc_q       <= {redirect_pc_i[31:2], 2'b00};
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q          <= pc_q + 32'd4;
        inflight_pc_q <= pc_q;
      end
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (deq)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Buffer payload needs no reset; the count qualifies every entry.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      buf_pc_q[wr_ptr_q]    <= inflight_pc_q;
      buf_instr_q[wr_ptr_q] <= imem_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      assert (count_q < CNT_W'(BUF_DEPTH))
        else $error("if_fetch_unit: push into full fetch buffer");
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: scoreboard of expected PCs popped on each
// decode handshake, plus cycle-exact checks of latency, stall, redirect and reset.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n0, reset_n1;
  logic [31:0] addr0, addr1, data0, data1;
  logic        read_n0, read_n1;
  logic        redirect0, redirect1;
  logic [31:0] redirect_pc0, redirect_pc1;
  logic        ready0, ready1;
  logic        valid0, valid1;
  logic [31:0] instr0, instr1, pc0, pc1;

  int tests = 0;
  int fails = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut0 (
    .clk(clk), .reset_n(reset_n0), .imem_addr_o(addr0), .imem_read_n_o(read_n0),
    .imem_data_i(data0), .redirect_i(redirect0), .redirect_pc_i(redirect_pc0),
    .id_ready_i(ready0), .id_valid_o(valid0), .id_instr_o(instr0), .id_pc_o(pc0));

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut1 (
    .clk(clk), .reset_n(reset_n1), .imem_addr_o(addr1), .imem_read_n_o(read_n1),
    .imem_data_i(data1), .redirect_i(redirect1), .redirect_pc_i(redirect_pc1),
    .id_ready_i(ready1), .id_valid_o(valid1), .id_instr_o(instr1), .id_pc_o(pc1));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + {2'b00, a[31:2]};
  endfunction

  // Synchronous IMEM models, one-cycle read latency.
  always @(posedge clk) begin
    data0 <= read_n0 ? 32'hDEAD_BEEF : mem_word(addr0);
    data1 <= read_n1 ? 32'hDEAD_BEEF : mem_word(addr1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample at negedge and retire any handshake against the scoreboard.
  task automatic smp();
    logic [31:0] e;
    @(negedge clk);
    if (valid0 && ready0) begin
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL sb0_unexpected: pc=%h instr=%h, required no handshake", pc0, instr0);
      end else begin
        e = q0.pop_front();
        if (pc0 !== e || instr0 !== mem_word(e)) begin
          fails++;
          $display("FAIL sb0_handshake: pc=%h instr=%h, required pc=%h instr=%h",
                   pc0, instr0, e, mem_word(e));
        end
      end
    end
    if (valid1 && ready1) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL sb1_unexpected: pc=%h instr=%h, required no handshake", pc1, instr1);
      end else begin
        e = q1.pop_front();
        if (pc1 !== e || instr1 !== mem_word(e)) begin
          fails++;
          $display("FAIL sb1_handshake: pc=%h instr=%h, required pc=%h instr=%h",
                   pc1, instr1, e, mem_word(e));
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n0 = 1'b0; reset_n1 = 1'b0;
    redirect0 = 1'b0; redirect1 = 1'b0;
    redirect_pc0 = '0; redirect_pc1 = '0;
    ready0 = 1'b0; ready1 = 1'b0;
    tick();
    smp();
    tests++;
    if (read_n0 !== 1'b1 || valid0 !== 1'b0 || instr0 !== 32'h0000_0013 || pc0 !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: read_n=%b valid=%b instr=%h pc=%h, required 1 0 00000013 0",
               read_n0, valid0, instr0, pc0);
    end
    tests++;
    if (addr0 !== 32'h0) begin
      fails++;
      $display("FAIL reset_addr: addr=%h, required 00000000", addr0);
    end
    tick();
    reset_n0 = 1'b1;
    ready0 = 1'b1;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) q0.push_back(32'(i * 4));
    for (int c = 0; c < 10; c++) begin
      smp();
      if (c < 2) begin
        tests++;
        if (valid0 !== 1'b0 || read_n0 !== 1'b0 || addr0 !== 32'(c * 4)) begin
          fails++;
          $display("FAIL stream_startup c%0d: valid=%b read_n=%b addr=%h, required 0 0 %h",
                   c, valid0, read_n0, addr0, 32'(c * 4));
        end
      end
      if (c == 2) begin
        tests++;
        if (valid0 !== 1'b1) begin
          fails++;
          $display("FAIL stream_first_valid: valid=%b, required 1", valid0);
        end
      end
      tick();
    end
    tests++;
    if (q0.size() != 0) begin
      fails++;
      $display("FAIL stream_drain: %0d expected words left, required 0", q0.size());
    end
  endtask

  task automatic test_stall();
    ready0 = 1'b0;
    for (int c = 10; c < 16; c++) begin
      smp();
      tests++;
      if (valid0 !== 1'b1 || pc0 !== 32'd32 || instr0 !== mem_word(32'd32)) begin
        fails++;
        $display("FAIL stall_head c%0d: valid=%b pc=%h instr=%h, required 1 00000020 %h",
                 c, valid0, pc0, instr0, mem_word(32'd32));
      end
      if (c >= 11) begin
        tests++;
        if (read_n0 !== 1'b1 || addr0 !== 32'd40 || dut0.count_q !== 2'd2) begin
          fails++;
          $display("FAIL stall_full c%0d: read_n=%b addr=%h count=%0d, required 1 00000028 2",
                   c, read_n0, addr0, dut0.count_q);
        end
      end
      tick();
    end
    ready0 = 1'b1;
    for (int i = 8; i < 14; i++) q0.push_back(32'(i * 4));
    for (int c = 16; c < 22; c++) begin
      smp();
      if (c == 16) begin
        tests++;
        if (read_n0 !== 1'b0 || addr0 !== 32'd40) begin
          fails++;
          $display("FAIL stall_resume: read_n=%b addr=%h, required 0 00000028", read_n0, addr0);
        end
      end
      tick();
    end
    tests++;
    if (q0.size() != 0) begin
      fails++;
      $display("FAIL stall_drain: %0d expected words left, required 0", q0.size());
    end
  endtask

  task automatic test_redirect();
    redirect0 = 1'b1;
    redirect_pc0 = 32'h40;
    q0.push_back(32'h40); q0.push_back(32'h44); q0.push_back(32'h48);
    smp();
    tests++;
    if (valid0 !== 1'b0 || read_n0 !== 1'b1) begin
      fails++;
      $display("FAIL redirect_T: valid=%b read_n=%b, required 0 1", valid0, read_n0);
    end
    tick();
    redirect0 = 1'b0;
    for (int c = 23; c < 28; c++) begin
      smp();
      if (c == 23) begin
        tests++;
        if (valid0 !== 1'b0 || read_n0 !== 1'b0 || addr0 !== 32'h40) begin
          fails++;
          $display("FAIL redirect_T1: valid=%b read_n=%b addr=%h, required 0 0 00000040",
                   valid0, read_n0, addr0);
        end
      end
      if (c == 24) begin
        tests++;
        if (valid0 !== 1'b0) begin
          fails++;
          $display("FAIL redirect_T2: valid=%b, required 0", valid0);
        end
      end
      if (c == 25) begin
        tests++;
        if (valid0 !== 1'b1 || pc0 !== 32'h40 || instr0 !== 32'hA000_0010) begin
          fails++;
          $display("FAIL redirect_T3: valid=%b pc=%h instr=%h, required 1 00000040 a0000010",
                   valid0, pc0, instr0);
        end
      end
      tick();
    end
    tests++;
    if (q0.size() != 0) begin
      fails++;
      $display("FAIL redirect_drain: %0d expected words left, required 0", q0.size());
    end
  endtask

  task automatic test_redirect_stall();
    ready0 = 1'b0;
    for (int c = 28; c < 31; c++) begin
      smp();
      tick();
    end
    redirect0 = 1'b1;
    redirect_pc0 = 32'h42;
    smp();
    tests++;
    if (valid0 !== 1'b0) begin
      fails++;
      $display("FAIL redir_stall_T: valid=%b, required 0", valid0);
    end
    tick();
    redirect0 = 1'b0;
    smp();
    tests++;
    if (valid0 !== 1'b0 || read_n0 !== 1'b0 || addr0 !== 32'h40 || dut0.count_q !== 2'd0) begin
      fails++;
      $display("FAIL redir_stall_T1: valid=%b read_n=%b addr=%h count=%0d, required 0 0 00000040 0",
               valid0, read_n0, addr0, dut0.count_q);
    end
    tick();
    for (int c = 33; c < 35; c++) begin
      smp();
      tick();
    end
    smp();
    tests++;
    if (valid0 !== 1'b1 || pc0 !== 32'h40 || read_n0 !== 1'b1) begin
      fails++;
      $display("FAIL redir_stall_head: valid=%b pc=%h read_n=%b, required 1 00000040 1",
               valid0, pc0, read_n0);
    end
    tick();
    ready0 = 1'b1;
    q0.push_back(32'h40); q0.push_back(32'h44); q0.push_back(32'h48); q0.push_back(32'h4C);
    for (int c = 36; c < 40; c++) begin
      smp();
      tick();
    end
    tests++;
    if (q0.size() != 0) begin
      fails++;
      $display("FAIL redir_stall_drain: %0d expected words left, required 0", q0.size());
    end
  endtask

  task automatic test_reset_mid();
    reset_n0 = 1'b0;
    smp();
    tests++;
    if (read_n0 !== 1'b1 || valid0 !== 1'b0) begin
      fails++;
      $display("FAIL midreset_during: read_n=%b valid=%b, required 1 0", read_n0, valid0);
    end
    tick();
    reset_n0 = 1'b1;
    for (int i = 0; i < 4; i++) q0.push_back(32'(i * 4));
    for (int c = 41; c < 47; c++) begin
      smp();
      if (c < 43) begin
        tests++;
        if (valid0 !== 1'b0 || read_n0 !== 1'b0 || addr0 !== 32'((c - 41) * 4)) begin
          fails++;
          $display("FAIL midreset_restart c%0d: valid=%b read_n=%b addr=%h, required 0 0 %h",
                   c, valid0, read_n0, addr0, 32'((c - 41) * 4));
        end
      end
      tick();
    end
    ready0 = 1'b0;
    tests++;
    if (q0.size() != 0) begin
      fails++;
      $display("FAIL midreset_drain: %0d expected words left, required 0", q0.size());
    end
  endtask

  task automatic test_wrap();
    reset_n1 = 1'b1;
    ready1 = 1'b1;
    q1.push_back(32'hFFFF_FFF8); q1.push_back(32'hFFFF_FFFC);
    q1.push_back(32'h0000_0000); q1.push_back(32'h0000_0004);
    for (int c = 0; c < 6; c++) begin
      smp();
      if (c == 2) begin
        tests++;
        if (addr1 !== 32'h0 || read_n1 !== 1'b0) begin
          fails++;
          $display("FAIL wrap_addr: addr=%h read_n=%b, required 00000000 0", addr1, read_n1);
        end
      end
      tick();
    end
    ready1 = 1'b0;
    tests++;
    if (q1.size() != 0) begin
      fails++;
      $display("FAIL wrap_drain: %0d expected words left, required 0", q1.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
